conv_window_sequencer: RTL and testbench
========================================

CONV_WINDOW_SEQUENCER -- requirements
Module: conv_window_sequencer

Interface
REQ-001 SHALL have parameter M_LEN, default 3, kernel side length (kernel rows = image words per window).
REQ-002 SHALL have parameter IMG_W, default 8, image width in words; IMG_H, default 8, image height in rows.
REQ-003 SHALL have parameter ADDR_W, default 18, BRAM address width; CONV_LAT, default 2, cycles from last o_selec_I to convolution result.
REQ-004 i_clk  input  1  sole clock, rising edge.
REQ-005 i_rst  input  1  reset, synchronous and active-high.
REQ-006 i_start  input  1  request one full-image pass; sampled only in IDLE.
REQ-007 o_addr_img  output  ADDR_W  feature-map BRAM read address.
REQ-008 o_addr_ker  output  ADDR_W  kernel BRAM read address.
REQ-009 o_selec_K  output  1  kernel-row capture strobe to convolution datapath.
REQ-010 o_selec_I  output  1  image-row capture strobe to convolution datapath.
REQ-011 o_out_valid  output  1  one-cycle pulse: datapath result for current window is valid.
REQ-012 o_out_row, o_out_col  output  ADDR_W each  window coordinates qualified by o_out_valid.
REQ-013 o_busy  output  1  pass in progress; o_done  output  1  one-cycle end-of-pass pulse.

Function
REQ-014 FSM states SHALL be IDLE, LOAD_K, FETCH_I, DRAIN, DONE.
REQ-015 IDLE -> LOAD_K on i_start=1; i_start in any other state SHALL be ignored.
REQ-016 LOAD_K SHALL drive o_addr_ker = 0..M_LEN-1 on M_LEN consecutive cycles, then go to FETCH_I.
REQ-017 FETCH_I SHALL visit windows row-major, r in 0..IMG_H-M_LEN, c in 0..IMG_W-M_LEN, k in 0..M_LEN-1 innermost, one address per cycle, o_addr_img = (r+k)*IMG_W + c.
REQ-018 o_selec_K / o_selec_I SHALL assert exactly one cycle after each kernel / image address issue (BRAM read latency 1).
REQ-019 o_out_valid SHALL pulse CONV_LAT cycles after the o_selec_I for k=M_LEN-1, with o_out_row/o_out_col = that window's r, c.
REQ-020 After the last window address FSM SHALL enter DRAIN, remain until the final o_out_valid, then enter DONE for one cycle (o_done=1), then IDLE.
REQ-021 o_busy SHALL be 1 in LOAD_K, FETCH_I, DRAIN, DONE; 0 in IDLE.
REQ-022 Address arithmetic SHALL be unsigned, ADDR_W wide; IMG_W*IMG_H > 2^ADDR_W is unsupported (elaboration check).
REQ-023 Address outputs SHALL hold last value when not issuing; strobes SHALL be 0 outside their issue-delayed cycles.
REQ-024 i_start held high through DONE SHALL begin a new pass on the cycle after returning to IDLE.

Reset
REQ-025 i_rst=1 SHALL force state IDLE and all outputs, counters and strobe/valid delay lines to 0 on the next clock edge.
REQ-026 Reset mid-pass SHALL abort with no o_out_valid or o_done pulse after reset deasserts.

Configuration
REQ-027 Macro CONV_SEQ_STALL_EN, when defined, SHALL add input i_hold (1 bit): while 1, FSM, counters, address outputs and delay lines SHALL freeze and strobes/pulses SHALL read 0.
REQ-028 Without CONV_SEQ_STALL_EN the port SHALL be absent and the sequencer SHALL never stall.

Structure
REQ-029 State encoding, default M_LEN/BIT_LEN/ADDR_W constants SHALL live in a shared package (conv_pkg) used with convolution and bram.
REQ-030 The strobe/valid delay line SHALL be a sub-module seq_delay_line (parameterised depth, reset-to-zero shift register).

Verification
REQ-031 IMG_W=IMG_H=4, CONV_LAT=2, i_start at cycle 0 -> o_addr_ker 0,1,2 at cycles 1-3; o_selec_K at 2-4.
REQ-032 Same setup -> o_addr_img sequence 0,4,8,1,5,9,4,8,12,5,9,13 at cycles 4-15; o_selec_I at 5-16.
REQ-033 Same setup -> o_out_valid at cycles 9,12,15,18 with (row,col)=(0,0),(0,1),(1,0),(1,1); o_done at 19; o_busy 1 for cycles 1-19.
REQ-034 i_rst pulsed at cycle 8 -> all outputs 0 from cycle 9; no o_out_valid/o_done; new i_start restarts from kernel address 0.
REQ-035 i_start pulsed at cycle 6 during pass -> ignored; exactly four o_out_valid pulses, one o_done.
REQ-036 CONV_SEQ_STALL_EN, i_hold=1 cycles 6-8 -> address sequence resumes unchanged at cycle 9; all later events shift by 3 cycles (o_done at 22).

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: constants and state encoding shared by the convolution sequencer,
// convolution datapath and BRAM wrappers.
// Ports: none (package).
package conv_pkg;

  localparam int unsigned DEF_M_LEN   = 3;   // kernel side length
  localparam int unsigned DEF_BIT_LEN = 8;   // datapath word width
  localparam int unsigned DEF_ADDR_W  = 18;  // BRAM address width

  // Sequencer FSM states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_K  = 3'd1,
    FETCH_I = 3'd2,
    DRAIN   = 3'd3,
    DONE    = 3'd4
  } seq_state_e;

endpackage : conv_pkg

// File: rtl/seq_delay_line.sv
// seq_delay_line: fixed-depth shift register with enable and synchronous
// reset-to-zero, used to align strobes and result tags with BRAM/datapath
// latency.
// Ports:
//   i_clk  clock (rising edge)
//   i_rst  synchronous active-high reset, clears every stage
//   i_en   advance the pipeline by one stage when 1, freeze when 0
//   i_d    WIDTH-bit input word
//   o_q    WIDTH-bit output, i_d delayed by DEPTH enabled cycles
module seq_delay_line #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH < 1) begin : g_depth_chk
    $error("seq_delay_line: DEPTH must be at least 1");
  end

  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  // Shift by one stage when enabled
  always_comb begin
    stage_d = stage_q;
    if (i_en) begin
      stage_d[0] = i_d;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign o_q = stage_q[DEPTH-1];

endmodule : seq_delay_line

// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: walks a sliding M_LEN x M_LEN window over an
// IMG_W x IMG_H feature map held in BRAM. Loads the kernel rows once, then
// issues one image-row address per cycle (row-major windows, kernel row
// innermost), strobes the datapath one cycle after each read, and tags the
// datapath result with the window coordinates CONV_LAT cycles later.
// Optional build macro: CONV_SEQ_STALL_EN adds i_hold, which freezes the
// whole sequencer and forces strobes/pulses low while asserted.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_start               start one full-image pass (sampled in IDLE only)
//   i_hold                stall request (CONV_SEQ_STALL_EN builds only)
//   o_addr_img/o_addr_ker feature-map / kernel BRAM read addresses
//   o_selec_K/o_selec_I   kernel / image row capture strobes
//   o_out_valid           result-valid pulse, with o_out_row/o_out_col
//   o_busy, o_done        pass in progress, end-of-pass pulse
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned M_LEN    = DEF_M_LEN,
  parameter int unsigned IMG_W    = 8,
  parameter int unsigned IMG_H    = 8,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned CONV_LAT = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
`ifdef CONV_SEQ_STALL_EN
  input  logic              i_hold,
`endif
  output logic [ADDR_W-1:0] o_addr_img,
  output logic [ADDR_W-1:0] o_addr_ker,
  output logic              o_selec_K,
  output logic              o_selec_I,
  output logic              o_out_valid,
  output logic [ADDR_W-1:0] o_out_row,
  output logic [ADDR_W-1:0] o_out_col,
  output logic              o_busy,
  output logic              o_done
);

  // Elaboration-time parameter checks
  localparam longint unsigned IMG_WORDS = 64'(IMG_W) * 64'(IMG_H);
  localparam longint unsigned ADDR_SPAN = 64'd1 << ADDR_W;

  if (IMG_WORDS > ADDR_SPAN) begin : g_addr_chk
    $error("conv_window_sequencer: IMG_W*IMG_H exceeds the ADDR_W address space");
  end
  if (M_LEN < 1 || M_LEN > IMG_W || M_LEN > IMG_H) begin : g_mlen_chk
    $error("conv_window_sequencer: M_LEN must be within 1..min(IMG_W,IMG_H)");
  end

  localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(M_LEN - 1);
  localparam logic [ADDR_W-1:0] C_LAST   = ADDR_W'(IMG_W - M_LEN);
  localparam logic [ADDR_W-1:0] R_LAST   = ADDR_W'(IMG_H - M_LEN);
  localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);
  localparam int unsigned       DRAIN_W  = $clog2(CONV_LAT + 1) + 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(CONV_LAT);
  localparam int unsigned       TAG_W    = 1 + 2 * ADDR_W;

  // Stall source
  logic hold_c;
`ifdef CONV_SEQ_STALL_EN
  assign hold_c = i_hold;
`else
  assign hold_c = 1'b0;
`endif

  seq_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   r_q, r_d;
  logic [ADDR_W-1:0]   c_q, c_d;
  logic [ADDR_W-1:0]   k_q, k_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [ADDR_W-1:0]   addr_img_q, addr_img_d;
  logic [ADDR_W-1:0]   addr_ker_q, addr_ker_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // Next-state, counters and registered outputs
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    k_d     = k_q;
    drain_d = drain_q;

    if (!hold_c) begin
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            state_d = LOAD_K;
            k_d     = '0;
          end
        end
        LOAD_K: begin
          // k_q doubles as the kernel-row index during the kernel load
          if (k_q == K_LAST) begin
            state_d = FETCH_I;
            r_d     = '0;
            c_d     = '0;
            k_d     = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
        FETCH_I: begin
          if (k_q != K_LAST) begin
            k_d = k_q + 1'b1;
          end else begin
            k_d = '0;
            if (c_q != C_LAST) begin
              c_d = c_q + 1'b1;
            end else begin
              c_d = '0;
              if (r_q != R_LAST) begin
                r_d = r_q + 1'b1;
              end else begin
                state_d = DRAIN;
                drain_d = '0;
              end
            end
          end
        end
        DRAIN: begin
          // Last result tag leaves the delay line CONV_LAT+1 cycles after the final issue
          if (drain_q == DRAIN_LAST) begin
            state_d = DONE;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Addresses follow the counters only while issuing, otherwise hold
    addr_ker_d = (state_d == LOAD_K) ? k_d : addr_ker_q;
    addr_img_d = (state_d == FETCH_I) ? ADDR_W'((r_d + k_d) * IMG_W_A + c_d) : addr_img_q;
    busy_d     = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      r_q        <= '0;
      c_q        <= '0;
      k_q        <= '0;
      drain_q    <= '0;
      addr_img_q <= '0;
      addr_ker_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      c_q        <= c_d;
      k_q        <= k_d;
      drain_q    <= drain_d;
      addr_img_q <= addr_img_d;
      addr_ker_q <= addr_ker_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Issue flags for the address presented this cycle
  logic issue_k_c, issue_i_c, last_k_c;
  assign issue_k_c = (state_q == LOAD_K);
  assign issue_i_c = (state_q == FETCH_I);
  assign last_k_c  = issue_i_c && (k_q == K_LAST);

  // BRAM read latency of one cycle before the capture strobes
  logic [1:0] sel_q;
  seq_delay_line #(
    .WIDTH (2),
    .DEPTH (1)
  ) u_sel_dly (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (!hold_c),
    .i_d   ({issue_k_c, issue_i_c}),
    .o_q   (sel_q)
  );

  // Window tag rides alongside the datapath: one read cycle plus CONV_LAT
  logic [TAG_W-1:0] tag_q;
  seq_delay_line #(
    .WIDTH (TAG_W),
    .DEPTH (1 + CONV_LAT)
  ) u_tag_dly (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (!hold_c),
    .i_d   ({last_k_c, r_q, c_q}),
    .o_q   (tag_q)
  );

  assign o_addr_img  = addr_img_q;
  assign o_addr_ker  = addr_ker_q;
  assign o_selec_K   = sel_q[1] & ~hold_c;
  assign o_selec_I   = sel_q[0] & ~hold_c;
  assign o_out_valid = tag_q[TAG_W-1] & ~hold_c;
  assign o_out_row   = tag_q[2*ADDR_W-1:ADDR_W];
  assign o_out_col   = tag_q[ADDR_W-1:0];
  assign o_busy      = busy_q;
  assign o_done      = done_q & ~hold_c;

endmodule : conv_window_sequencer

// File: tb/tb_conv_window_sequencer.sv
// tb_conv_window_sequencer: scoreboard bench for conv_window_sequencer with a
// 4x4 image and 3x3 kernel. Expected events are generated from an independent
// window-walk model when a pass is started and retired cycle by cycle.
module tb_conv_window_sequencer;

  localparam int M   = 3;
  localparam int W   = 4;
  localparam int H   = 4;
  localparam int AW  = 18;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
`ifdef CONV_SEQ_STALL_EN
  logic          hold = 1'b0;
`endif
  logic [AW-1:0] addr_img, addr_ker, out_row, out_col;
  logic          selec_k, selec_i, out_valid, busy, done;

  conv_window_sequencer #(
    .M_LEN    (M),
    .IMG_W    (W),
    .IMG_H    (H),
    .ADDR_W   (AW),
    .CONV_LAT (LAT)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
`ifdef CONV_SEQ_STALL_EN
    .i_hold      (hold),
`endif
    .o_addr_img  (addr_img),
    .o_addr_ker  (addr_ker),
    .o_selec_K   (selec_k),
    .o_selec_I   (selec_i),
    .o_out_valid (out_valid),
    .o_out_row   (out_row),
    .o_out_col   (out_col),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int a;
    int b;
  } ev_t;

  ev_t q_ker[$];
  ev_t q_img[$];
  ev_t q_val[$];
  int  q_sk[$];
  int  q_si[$];
  int  q_done[$];
  bit  busy_map [0:2047];

  int            checks = 0;
  int            errors = 0;
  bit            mon_en = 1'b0;
  logic [AW-1:0] exp_ker = '0;
  logic [AW-1:0] exp_img = '0;
  int            n_valid = 0;
  int            n_done = 0;

  function automatic int sh(input int e, input int ha, input int hl);
    return (hl > 0 && e >= ha) ? e + hl : e;
  endfunction

  // Model of one pass started in cycle t0, optionally stalled hl cycles from ha
  task automatic push_pass(input int t0, input int ha, input int hl);
    int idx;
    int t;
    int done_c;
    for (int i = 0; i < M; i++) begin
      q_ker.push_back('{sh(t0 + 1 + i, ha, hl), i, 0});
      q_sk.push_back(sh(t0 + 2 + i, ha, hl));
    end
    idx = 0;
    for (int r = 0; r <= H - M; r++) begin
      for (int c = 0; c <= W - M; c++) begin
        for (int k = 0; k < M; k++) begin
          t = t0 + 1 + M + idx;
          q_img.push_back('{sh(t, ha, hl), (r + k) * W + c, 0});
          q_si.push_back(sh(t + 1, ha, hl));
          if (k == M - 1) q_val.push_back('{sh(t + 1 + LAT, ha, hl), r, c});
          idx++;
        end
      end
    end
    done_c = sh(t0 + M + idx + 1 + LAT + 1, ha, hl);
    q_done.push_back(done_c);
    for (int e = t0 + 1; e <= done_c; e++) busy_map[e] = 1'b1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    wait_cycles(3);
    @(negedge clk);
    checks++;
    if ({addr_img, addr_ker} !== '0) begin
      errors++;
      $display("FAIL reset_addr got img=%0d ker=%0d exp 0/0", addr_img, addr_ker);
    end
    checks++;
    if ({selec_k, selec_i, out_valid, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl got %05b exp 00000", {selec_k, selec_i, out_valid, busy, done});
    end
    checks++;
    if ({out_row, out_col} !== '0) begin
      errors++;
      $display("FAIL reset_tag got row=%0d col=%0d exp 0/0", out_row, out_col);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    wait_cycles(2);
  endtask

  task automatic test_single_pass();
    int v0, d0;
    v0 = n_valid;
    d0 = n_done;
    start = 1'b1;
    push_pass(cyc, 0, 0);
    wait_cycles(1);
    start = 1'b0;
    wait_cycles(25);
    checks++;
    if (n_valid - v0 != 4) begin
      errors++;
      $display("FAIL single_valid_count got %0d exp 4", n_valid - v0);
    end
    checks++;
    if (n_done - d0 != 1) begin
      errors++;
      $display("FAIL single_done_count got %0d exp 1", n_done - d0);
    end
    checks++;
    if (q_img.size() != 0 || q_val.size() != 0 || q_done.size() != 0) begin
      errors++;
      $display("FAIL single_pending got img=%0d val=%0d done=%0d exp 0", q_img.size(), q_val.size(), q_done.size());
    end
  endtask

  task automatic test_ignore_start();
    int t0, v0, d0;
    v0 = n_valid;
    d0 = n_done;
    t0 = cyc;
    start = 1'b1;
    push_pass(t0, 0, 0);
    wait_cycles(1);
    start = 1'b0;
    wait_cycles(t0 + 6 - cyc);
    start = 1'b1;
    wait_cycles(1);
    start = 1'b0;
    wait_cycles(30);
    checks++;
    if (n_valid - v0 != 4) begin
      errors++;
      $display("FAIL ignore_valid_count got %0d exp 4", n_valid - v0);
    end
    checks++;
    if (n_done - d0 != 1) begin
      errors++;
      $display("FAIL ignore_done_count got %0d exp 1", n_done - d0);
    end
  endtask

  task automatic test_reset_mid_pass();
    int t0, v0, d0;
    t0 = cyc;
    start = 1'b1;
    push_pass(t0, 0, 0);
    wait_cycles(1);
    start = 1'b0;
    wait_cycles(t0 + 8 - cyc);
    rst = 1'b1;
    wait_cycles(1);
    q_ker.delete();
    q_img.delete();
    q_val.delete();
    q_sk.delete();
    q_si.delete();
    q_done.delete();
    for (int e = cyc; e < 2048; e++) busy_map[e] = 1'b0;
    exp_ker = '0;
    exp_img = '0;
    rst = 1'b0;
    v0 = n_valid;
    d0 = n_done;
    wait_cycles(15);
    checks++;
    if (n_valid != v0 || n_done != d0) begin
      errors++;
      $display("FAIL abort_pulses got valid=%0d done=%0d exp 0/0", n_valid - v0, n_done - d0);
    end
    start = 1'b1;
    push_pass(cyc, 0, 0);
    wait_cycles(1);
    start = 1'b0;
    wait_cycles(25);
    checks++;
    if (n_valid - v0 != 4 || q_done.size() != 0) begin
      errors++;
      $display("FAIL restart got valid=%0d pending_done=%0d exp 4/0", n_valid - v0, q_done.size());
    end
  endtask

  task automatic test_back_to_back();
    int t0, v0, d0;
    v0 = n_valid;
    d0 = n_done;
    t0 = cyc;
    start = 1'b1;
    push_pass(t0, 0, 0);
    push_pass(t0 + 20, 0, 0);
    wait_cycles(t0 + 21 - cyc);
    start = 1'b0;
    wait_cycles(25);
    checks++;
    if (n_valid - v0 != 8) begin
      errors++;
      $display("FAIL b2b_valid_count got %0d exp 8", n_valid - v0);
    end
    checks++;
    if (n_done - d0 != 2 || q_done.size() != 0) begin
      errors++;
      $display("FAIL b2b_done_count got %0d pending=%0d exp 2/0", n_done - d0, q_done.size());
    end
  endtask

`ifdef CONV_SEQ_STALL_EN
  task automatic test_stall();
    int t0, d0;
    d0 = n_done;
    t0 = cyc;
    start = 1'b1;
    push_pass(t0, t0 + 6, 3);
    wait_cycles(1);
    start = 1'b0;
    wait_cycles(t0 + 6 - cyc);
    hold = 1'b1;
    wait_cycles(3);
    hold = 1'b0;
    wait_cycles(25);
    checks++;
    if (n_done - d0 != 1 || q_val.size() != 0) begin
      errors++;
      $display("FAIL stall_end got done=%0d pending_val=%0d exp 1/0", n_done - d0, q_val.size());
    end
  endtask
`endif

  initial begin
    // Scoreboard monitor: retires expected events at the negative edge
    fork
      forever begin
        @(negedge clk);
        if (mon_en) begin
          bit e_sk, e_si, e_v, e_d, e_b;
          ev_t ev;
          if (q_ker.size() > 0 && q_ker[0].cyc == cyc) begin
            exp_ker = AW'(q_ker[0].a);
            void'(q_ker.pop_front());
          end
          if (q_img.size() > 0 && q_img[0].cyc == cyc) begin
            exp_img = AW'(q_img[0].a);
            void'(q_img.pop_front());
          end
          e_sk = (q_sk.size() > 0 && q_sk[0] == cyc);
          if (e_sk) void'(q_sk.pop_front());
          e_si = (q_si.size() > 0 && q_si[0] == cyc);
          if (e_si) void'(q_si.pop_front());
          e_v = (q_val.size() > 0 && q_val[0].cyc == cyc);
          ev = '{0, 0, 0};
          if (e_v) ev = q_val.pop_front();
          e_d = (q_done.size() > 0 && q_done[0] == cyc);
          if (e_d) void'(q_done.pop_front());
          e_b = busy_map[cyc];
          if (out_valid === 1'b1) n_valid++;
          if (done === 1'b1) n_done++;

          checks++;
          if (addr_ker !== exp_ker) begin
            errors++;
            $display("FAIL addr_ker cyc=%0d got %0d exp %0d", cyc, addr_ker, exp_ker);
          end
          checks++;
          if (addr_img !== exp_img) begin
            errors++;
            $display("FAIL addr_img cyc=%0d got %0d exp %0d", cyc, addr_img, exp_img);
          end
          checks++;
          if (selec_k !== e_sk) begin
            errors++;
            $display("FAIL selec_k cyc=%0d got %0b exp %0b", cyc, selec_k, e_sk);
          end
          checks++;
          if (selec_i !== e_si) begin
            errors++;
            $display("FAIL selec_i cyc=%0d got %0b exp %0b", cyc, selec_i, e_si);
          end
          checks++;
          if (out_valid !== e_v) begin
            errors++;
            $display("FAIL out_valid cyc=%0d got %0b exp %0b", cyc, out_valid, e_v);
          end
          if (e_v) begin
            checks++;
            if (out_row !== AW'(ev.a) || out_col !== AW'(ev.b)) begin
              errors++;
              $display("FAIL out_rc cyc=%0d got (%0d,%0d) exp (%0d,%0d)", cyc, out_row, out_col, ev.a, ev.b);
            end
          end
          checks++;
          if (done !== e_d) begin
            errors++;
            $display("FAIL done cyc=%0d got %0b exp %0b", cyc, done, e_d);
          end
          checks++;
          if (busy !== e_b) begin
            errors++;
            $display("FAIL busy cyc=%0d got %0b exp %0b", cyc, busy, e_b);
          end
        end
      end
    join_none

    test_reset();
    test_single_pass();
    test_ignore_start();
    test_reset_mid_pass();
    test_back_to_back();
`ifdef CONV_SEQ_STALL_EN
    test_stall();
`endif
    wait_cycles(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_conv_window_sequencer
